// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: ID/EX hazard sources in, stall/flush controls out.
// There is no valid/ready handshake here; every signal is a level that is meaningful in every cycle.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic [REG_W-1:0] idex_rt;
  logic             idex_memread;
  logic             idex_mdu_start;
  logic             ifid_mdu_use;
  logic             flush;
  logic             pc_hold;
  logic             ifid_hold;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ifid_rs, ifid_rt, idex_rt, idex_memread, idex_mdu_start, ifid_mdu_use, flush,
    input  pc_hold, ifid_hold, idex_bubble, ifid_flush, mdu_busy, stall_count
  );

  modport slave (
    input  ifid_rs, ifid_rt, idex_rt, idex_memread, idex_mdu_start, ifid_mdu_use, flush,
    output pc_hold, ifid_hold, idex_bubble, ifid_flush, mdu_busy, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: multi-cycle load-use stalls, MDU busy tracking,
// flush priority and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int LOAD_STALL = 1,
  parameter int MDU_LAT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave bus
);
  localparam int LD_W  = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;
  localparam int MDU_W = $clog2(MDU_LAT + 1);
  localparam logic [LD_W-1:0]  LD_RELOAD  = LD_W'(LOAD_STALL - 1);
  localparam logic [MDU_W-1:0] MDU_RELOAD = MDU_W'(MDU_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [LD_W-1:0]  r_ld_cnt;
  logic [MDU_W-1:0] r_mdu_cnt;
  logic             r_mdu_busy;
  logic [CNT_W-1:0] r_stall_count;

  logic w_ld_hit;
  logic w_ld_busy;
  logic w_mdu_hit;
  logic w_stall;

  // $0 is hard-wired to zero, so a load targeting it can never feed a dependent
  assign w_ld_hit  = bus.idex_memread && (bus.idex_rt != '0) &&
                     ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
  assign w_ld_busy = (r_ld_cnt != '0);
  assign w_mdu_hit = bus.ifid_mdu_use && (r_mdu_busy || bus.idex_mdu_start);
  assign w_stall   = w_ld_hit || w_ld_busy || w_mdu_hit;

  always_comb begin
    bus.pc_hold     = 1'b0;
    bus.ifid_hold   = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.ifid_flush  = 1'b0;
    if (bus.flush) begin
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else if (w_stall) begin
      bus.pc_hold     = 1'b1;
      bus.ifid_hold   = 1'b1;
      bus.idex_bubble = 1'b1;
    end
  end

  assign bus.mdu_busy    = r_mdu_busy;
  assign bus.stall_count = r_stall_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ld_cnt      <= '0;
      r_mdu_cnt     <= '0;
      r_mdu_busy    <= 1'b0;
      r_stall_count <= '0;
    end else begin
      // A new load hit is only accepted once the previous load stall has drained
      if (bus.flush) begin
        r_ld_cnt <= '0;
      end else if (w_ld_busy) begin
        r_ld_cnt <= r_ld_cnt - LD_W'(1);
      end else if (w_ld_hit) begin
        r_ld_cnt <= LD_RELOAD;
      end

      // The MDU keeps running across flushes; a new start restarts the latency window
      if (bus.idex_mdu_start) begin
        r_mdu_cnt  <= MDU_RELOAD;
        r_mdu_busy <= 1'b1;
      end else begin
        if (r_mdu_cnt != '0) begin
          r_mdu_cnt <= r_mdu_cnt - MDU_W'(1);
        end
        r_mdu_busy <= (r_mdu_cnt > MDU_W'(1));
      end

      if (w_stall && !bus.flush && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard control unit for the 5-stage MIPS pipeline, the successor to the single-cycle load-use detector. It sits between the IF/ID and ID/EX pipeline registers and drives PC hold, IF/ID hold, IF/ID flush and ID/EX bubble. It adds three things:
- configurable multi-cycle load-use stalls, for slower data memory;
- a busy tracker for the multi-cycle multiply/divide unit (MDU);
- a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_W, 5: register-address width.
- LOAD_STALL, 1: stall cycles per load-use hazard. Must be at least 1.
- MDU_LAT, 4: cycles the MDU is busy after issue. Must be at least 1.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ifid_rs  in  REG_W  rs of the instruction in ID.
- ifid_rt  in  REG_W  rt of the instruction in ID.
- idex_rt  in  REG_W  destination rt of the instruction in EX.
- idex_memread  in  1  instruction in EX is a load.
- idex_mdu_start  in  1  instruction in EX issues a multiply/divide.
- ifid_mdu_use  in  1  instruction in ID reads HI/LO or is an MDU op.
- flush  in  1  taken branch/jump resolved in EX.
- pc_hold  out  1  PC must not update.
- ifid_hold  out  1  IF/ID must not update.
- idex_bubble  out  1  load a NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID to a NOP.
- mdu_busy  out  1  MDU result not yet available.
- stall_count  out  CNT_W  total stall cycles since reset; saturates.

## Operation
- Load-use detect (combinational), ld_hit:
  - idex_memread=1, and
  - idex_rt≠0, and
  - idex_rt==ifid_rs or idex_rt==ifid_rt.
  - Register $0 never causes a hazard.
- Load stall counter ld_cnt (range 0..LOAD_STALL-1):
  - On ld_hit with ld_cnt=0 and flush=0, ld_cnt loads LOAD_STALL-1.
  - While ld_cnt≠0, it decrements each cycle and the stall continues; ld_hit is ignored during this time.
- MDU counter mdu_cnt (range 0..MDU_LAT):
  - idex_mdu_start=1 loads MDU_LAT.
  - Otherwise it decrements while nonzero.
  - mdu_busy = (mdu_cnt≠0).
  - A start while busy reloads to MDU_LAT.
- mdu_hit = ifid_mdu_use and (mdu_busy or idex_mdu_start).
- Output priority, highest first:
  1. flush: ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0; ld_cnt cleared to 0.
  2. stall (ld_hit, or ld_cnt≠0, or mdu_hit): pc_hold=1, ifid_hold=1, idex_bubble=1, ifid_flush=0.
  3. none: all four outputs 0.
- flush never cancels mdu_cnt; the MDU operation is already executing.
- stall_count increments by 1 in every cycle where priority 2 applies and flush=0. It holds at 2^CNT_W-1.
- Reset (rst_n=0 at a rising edge) clears ld_cnt, mdu_cnt and stall_count. Reset takes effect mid-stall or mid-MDU-operation.

## Timing
- pc_hold, ifid_hold, idex_bubble and ifid_flush are combinational from the inputs and registered state. They are valid in the same cycle as the hazard, with zero-cycle latency.
- mdu_busy and stall_count are registered outputs.
- Output values after reset, while inputs are idle: all outputs 0, stall_count=0.
- Load-use hazard first seen in cycle T: stall asserted in cycles T through T+LOAD_STALL-1, then released. With LOAD_STALL=1 this is exactly one stall cycle.
- MDU issue in cycle S: mdu_busy is high in S+1 through S+MDU_LAT. An MDU consumer sitting in ID is stalled in S through S+MDU_LAT and proceeds in S+MDU_LAT+1.
- Simultaneous load hazard and MDU hazard: a single stall. Each counter runs independently; the stall lasts until both clear.
- Flush in any stall cycle: that cycle is a flush, not a stall. The load stall ends; MDU tracking continues. If mdu_hit still holds next cycle (a new instruction is in ID), it stalls then.

## Test plan
- Reset, LOAD_STALL=1: idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle, then idex_memread=0 → stall outputs 1 for exactly one cycle, stall_count=1.
- Zero register: idex_memread=1, idex_rt=0, ifid_rs=0, ifid_rt=0 → no stall, stall_count stays 0.
- LOAD_STALL=3: hit on rt=9 in cycle T, with the bubble removing memread in T+1 → stall in T, T+1 and T+2; released in T+3; stall_count=3.
- MDU_LAT=4: idex_mdu_start=1 in S, ifid_mdu_use=1 held → mdu_busy in S+1..S+4; stall in S..S+4; pc_hold=0 in S+5.
- Flush in T+1 of a LOAD_STALL=3 stall → T+1: ifid_flush=1, idex_bubble=1, pc_hold=0; T+2: no stall; stall_count=1.
- CNT_W=4 with a continuous MDU stall held for 20 cycles → stall_count saturates at 15. rst_n=0 for one edge during the stall → all counters and outputs return to 0.
